aes_encryption_iter: RTL and testbench
======================================

Name: aes_encryption_iter

Overview:
Iterative AES-128 encryption core. It is the encrypt-side counterpart of the team's pipelined AES-128 decryption block, and shares its byte ordering and key format, so ciphertext from this block decrypts directly in that path. One round is computed per clock and the round keys are expanded on the fly. A valid/ready handshake is used on both the input and output sides.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.
CLR_OUT, 0, when 1, cipher_text reads 0 whenever out_valid is low; when 0, cipher_text holds the last result.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  plain_text/aes_key are valid.
in_ready  output  1  core can accept a block.
plain_text  input  128  plaintext block; byte0 = [127:120], column-major state per FIPS-197.
aes_key  input  128  cipher key, same byte order.
cipher_text  output  128  ciphertext block.
out_valid  output  1  cipher_text is valid.
out_ready  input  1  consumer accepts cipher_text.
busy  output  1  a block is in flight (ROUND or DONE).

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. The state register, round-key register, round counter and cipher_text all clear to 0. in_ready=1 one cycle after reset releases (combinational from IDLE). out_valid=0, busy=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On the in_valid&&in_ready edge: st <= plain_text ^ aes_key, rk <= aes_key, rnd <= 1, go to ROUND.
  - Inputs are sampled only on this edge. Changes to inputs afterwards are ignored.
- ROUND (rnd = 1..10, one per edge):
  - Next round key nk = expand(rk, rcon[rnd]).
    - w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
    - rcon = 01,02,04,08,10,20,40,80,1b,36.
  - st <= MixColumns(ShiftRows(SubBytes(st))) ^ nk for rnd 1..9.
  - For rnd = 10, MixColumns is bypassed.
  - rk <= nk; rnd <= rnd+1.
  - After the rnd=10 edge: cipher_text <= result, go to DONE.
- DONE:
  - out_valid=1; cipher_text is held stable.
  - On out_valid&&out_ready: go to IDLE and drop out_valid.
  - Backpressure of any length is held without corrupting data.
- Latency: out_valid rises exactly 10 clock edges after the accepting edge.
  - If out_ready is already high, the minimum initiation interval is 12 cycles (accept, 10 rounds, drain edge).
  - in_ready stays low in ROUND and DONE. A new block cannot be accepted on the same edge as the output drain; it is accepted at the earliest on the following edge.
- busy = (FSM != IDLE).
- rnd is 4 bits and never exceeds 10. Any illegal FSM encoding recovers to IDLE.
- Asserting reset mid-ROUND or mid-DONE aborts the block immediately: no out_valid is produced and all registers clear.
- Logic sizing: 16 S-box instances for the state plus 4 for key expansion, built from the existing S_Box and g_function modules.
- MixColumns uses xtime: {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0).

Test Plan:
1. FIPS-197 C.1 vector.
   - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1.
   - Required: ct 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 edges after accept, high for 1 cycle.
2. FIPS-197 Appendix B vector.
   - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
   - Required: ct 3925841d02dc09fbdc118597196a0b32; the internal st after round 1 equals a49c7ff2689f352b6b5bea43026a5049.
3. Backpressure.
   - Stimulus: hold out_ready=0 for 20 cycles after out_valid, with in_valid=1 and new data throughout.
   - Required: cipher_text stable and in_ready=0 for all 20 cycles. One cycle after out_ready=1, in_ready=1 and the next block is accepted.
4. Input change mid-block.
   - Stimulus: change plain_text/aes_key to all-ones during ROUND cycles 3..8 of vector 1.
   - Required: ct still equals 69c4e0d86a7b0430d8cdb78070b4c55a.
5. Reset mid-operation.
   - Stimulus: pulse rst=0 during round 5, between clock edges.
   - Required: out_valid, busy and cipher_text go to 0 immediately (asynchronous); no out_valid follows; in_ready=1 after release.
6. Round-trip with the decryption block.
   - Stimulus: key 0f1571c947d9e8590cb7add6af7f6798, pt 0123456789abcdeffedcba9876543210.
   - Required: ct ff0b844a0853bf7c6934ab4364148fb9, and feeding ct to the decryption block returns the original pt.

Source files
------------

// File: rtl/aes_encryption_iter.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded
// on the fly, valid/ready handshake on both sides. Byte 0 of every 128-bit
// block is bits [127:120], and the state is column-major as in FIPS-197.

// AES forward S-box as a 256-entry constant table, entry 0 in the top byte.
module S_Box (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bitBase;

  // Entry k sits at bit offset 8*(255-k), which is simply {~k, 3'b000}.
  assign bitBase  = {~in_byte, 3'b000};
  assign out_byte = SBOX_TABLE[bitBase +: 8];
endmodule

// Key-schedule g function: SubWord(RotWord(w)) with the round constant folded in.
module g_function (
  input  logic [31:0] in_word,
  input  logic [7:0]  rcon,
  output logic [31:0] out_word
);
  logic [31:0] rotWord;
  logic [31:0] subWord;

  assign rotWord = {in_word[23:0], in_word[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    S_Box u_sbox (
      .in_byte  (rotWord[8*i +: 8]),
      .out_byte (subWord[8*i +: 8])
    );
  end

  assign out_word = subWord ^ {rcon, 24'h000000};
endmodule

module aes_encryption_iter #(
  parameter int NR      = 10,
  parameter bit CLR_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain_text,
  input  logic [127:0] aes_key,
  output logic [127:0] cipher_text,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  if (NR != 10) begin : g_nr_check
    $error("aes_encryption_iter supports only NR = 10 (AES-128)");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [7:0]   rcon;
  logic [31:0]  gWord;
  logic [127:0] nextKey;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] roundPre;
  logic [127:0] roundOut;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for the key being derived in the current round.
  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  g_function u_gfunc (
    .in_word  (rk_q[31:0]),
    .rcon     (rcon),
    .out_word (gWord)
  );

  assign nextKey[127:96] = rk_q[127:96] ^ gWord;
  assign nextKey[95:64]  = rk_q[95:64]  ^ nextKey[127:96];
  assign nextKey[63:32]  = rk_q[63:32]  ^ nextKey[95:64];
  assign nextKey[31:0]   = rk_q[31:0]   ^ nextKey[63:32];

  for (genvar i = 0; i < 16; i++) begin : g_subbytes
    S_Box u_sbox (
      .in_byte  (st_q[127-8*i -: 8]),
      .out_byte (sb[i])
    );
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end

    assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_pack
    assign roundPre[127-8*i -: 8] = (rnd_q == 4'd10) ? sr[i] : mc[i];
  end

  assign roundOut = roundPre ^ nextKey;

  // Next-state and handshake decode; inputs are captured only on the accept edge.
  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    rk_d      = rk_q;
    rnd_d     = rnd_q;
    ct_d      = ct_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = plain_text ^ aes_key;
          rk_d    = aes_key;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d = roundOut;
        rk_d = nextKey;
        if (rnd_q >= 4'd10) begin
          ct_d    = roundOut;
          rnd_d   = 4'd0;
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-key, round-counter and result registers; reset aborts any block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      ct_q    <= ct_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign cipher_text = (CLR_OUT && !out_valid) ? '0 : ct_q;

endmodule

// File: tb/tb_aes_encryption_iter.sv
// Scoreboard bench for aes_encryption_iter: a stimulus process pushes the
// expected ciphertext of every accepted block, a monitor pops and compares
// whenever the core hands a result over. Random blocks use a byte-level AES
// model that derives its S-box from GF(2^8) inversion plus the affine map.
module tb_aes_encryption_iter;

  typedef logic [0:15][7:0]   st16_t;
  typedef logic [0:10][127:0] rks_t;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] key;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] aes_key;
  logic [127:0] cipher_text;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  logic readyCmd  = 1'b1;
  logic randReady = 1'b0;
  logic randBit   = 1'b1;

  int   nVectors     = 0;
  int   nMiscompares = 0;
  int   cyc          = 0;
  exp_t sbq[$];

  logic [7:0] sboxT [256];
  logic [7:0] invT  [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] S_KEY  = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] S_PT   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] S_CT   = 128'hff0b844a0853bf7c6934ab4364148fb9;

  aes_encryption_iter #(.NR(10), .CLR_OUT(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .plain_text  (plain_text),
    .aes_key     (aes_key),
    .cipher_text (cipher_text),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign out_ready = randReady ? randBit : readyCmd;

  // Cycle counter used to measure accept-to-valid latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Random consumer backpressure source.
  always @(posedge clk) begin
    #1 randBit = 1'($urandom_range(0, 1));
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic buildTables();
    logic [7:0] inv;
    logic [7:0] x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      if (v != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sboxT[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int v = 0; v < 256; v++) invT[sboxT[v]] = 8'(v);
  endtask

  function automatic rks_t expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    rks_t        rks;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sboxT[tmp[23:16]], sboxT[tmp[15:8]], sboxT[tmp[7:0]], sboxT[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  function automatic logic [127:0] aesEncrypt(input logic [127:0] pt, input logic [127:0] key);
    rks_t       rks = expandKey(key);
    st16_t      s;
    st16_t      t;
    logic [7:0] a [4];
    s = pt ^ rks[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sboxT[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
          for (int j = 0; j < 4; j++)
            s[4*c+j] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03) ^ a[(j+2)%4] ^ a[(j+3)%4];
        end
      end else begin
        s = t;
      end
      s = s ^ rks[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] aesDecrypt(input logic [127:0] ct, input logic [127:0] key);
    rks_t       rks = expandKey(key);
    st16_t      s;
    st16_t      t;
    logic [7:0] a [4];
    s = ct ^ rks[10];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c-w+4)%4)+w];
      for (int i = 0; i < 16; i++) t[i] = invT[t[i]];
      s = t ^ rks[r];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          for (int j = 0; j < 4; j++)
            s[4*c+j] = gmul(a[j], 8'h0e) ^ gmul(a[(j+1)%4], 8'h0b) ^
                       gmul(a[(j+2)%4], 8'h0d) ^ gmul(a[(j+3)%4], 8'h09);
        end
      end
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    nVectors++;
    if (act !== req) begin
      nMiscompares++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic failNote(input string name);
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL %s: timed out, required event never occurred", name);
  endtask

  // Presents one block, waits for acceptance and records its expected result.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key,
                               input logic [127:0] ct, output int waited);
    exp_t e;
    waited = 0;
    @(posedge clk);
    #1;
    plain_text = pt;
    aes_key    = key;
    in_valid   = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        failNote("accept");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    e.ct  = ct;
    e.pt  = pt;
    e.key = key;
    e.acc = cyc;
    sbq.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    for (int i = 0; i < limit && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      failNote("output drain");
      sbq.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compares every handed-over result against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic prevValid;
    logic justPopped;
    int   riseCyc;
    if (!rst) begin
      prevValid  = 1'b0;
      justPopped = 1'b0;
    end else begin
      if (justPopped) checkOutput("valid one cycle", 128'(out_valid), 128'(0));
      justPopped = 1'b0;
      if (out_valid) begin
        if (!prevValid) riseCyc = cyc;
        if (sbq.size() == 0) begin
          checkOutput("unexpected out_valid", 128'(out_valid), 128'(0));
        end else if (out_ready) begin
          e = sbq.pop_front();
          checkOutput("ciphertext", cipher_text, e.ct);
          checkOutput("latency", 128'(riseCyc - e.acc), 128'(10));
          checkOutput("round trip", aesDecrypt(cipher_text, e.key), e.pt);
          justPopped = 1'b1;
        end else begin
          checkOutput("held ciphertext", cipher_text, sbq[0].ct);
        end
      end
      prevValid = out_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           w;
    int           n;
    logic         saw;
    logic [127:0] pt;
    logic [127:0] key;

    buildTables();
    rst        = 1'b0;
    in_valid   = 1'b0;
    plain_text = '0;
    aes_key    = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    @(negedge clk);
    checkOutput("reset in_ready", 128'(in_ready), 128'(1));
    checkOutput("reset out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset cipher_text", cipher_text, 128'(0));

    $display("[TB] FIPS-197 C.1 vector");
    applyStimulus(C1_PT, C1_KEY, C1_CT, w);
    @(negedge clk);
    checkOutput("busy in round", 128'(busy), 128'(1));
    checkOutput("in_ready in round", 128'(in_ready), 128'(0));
    waitDrain(40);

    $display("[TB] FIPS-197 Appendix B vector");
    applyStimulus(B_PT, B_KEY, B_CT, w);
    @(posedge clk);
    #1 checkOutput("round 1 state", dut.st_q, B_R1);
    waitDrain(40);

    $display("[TB] input change mid-block");
    applyStimulus(C1_PT, C1_KEY, C1_CT, w);
    repeat (2) @(posedge clk);
    #1;
    plain_text = '1;
    aes_key    = '1;
    repeat (6) @(posedge clk);
    #1;
    plain_text = '0;
    aes_key    = '0;
    waitDrain(40);

    $display("[TB] round trip vector");
    applyStimulus(S_PT, S_KEY, S_CT, w);
    waitDrain(40);

    $display("[TB] backpressure");
    readyCmd = 1'b0;
    applyStimulus(B_PT, B_KEY, B_CT, w);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) failNote("out_valid under backpressure");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid   = 1'b1;
      plain_text = {$urandom, $urandom, $urandom, $urandom};
      aes_key    = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checkOutput("in_ready held low", 128'(in_ready), 128'(0));
      checkOutput("out_valid held", 128'(out_valid), 128'(1));
    end
    @(posedge clk);
    #1 readyCmd = 1'b1;
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(pt, key, aesEncrypt(pt, key), w);
    checkOutput("accept right after drain", 128'(w), 128'(0));
    waitDrain(40);

    $display("[TB] random blocks with random backpressure");
    randReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(pt, key, aesEncrypt(pt, key), w);
    end
    waitDrain(200);
    randReady = 1'b0;

    $display("[TB] reset mid-operation");
    applyStimulus(C1_PT, C1_KEY, C1_CT, w);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("abort out_valid", 128'(out_valid), 128'(0));
    checkOutput("abort busy", 128'(busy), 128'(0));
    checkOutput("abort cipher_text", cipher_text, 128'(0));
    sbq.delete();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after release", 128'(in_ready), 128'(1));
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    checkOutput("no valid after abort", 128'(saw), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
